cgra_launch_ctrl: RTL and testbench

Host-side initiator for the CGRA kernel handshake. The CGRA raises Computation_Done in response to Computation_Start; this block drives Computation_Start and consumes Computation_Done, sitting between the host register interface and the CGRA top. It runs the four-phase sequence: Start up, Done up, Start down, Done down. It also measures kernel latency, counts completed runs, and guards against a hung array with a timeout and against protocol violations.

---
 rtl/cgra_ctrl_pkg.sv | 20 ++
 rtl/cgra_sat_counter.sv | 28 ++
 rtl/cgra_launch_ctrl.sv | 116 +++++++++++
 tb/tb_cgra_launch_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cgra_ctrl_pkg.sv
// Shared definitions for CGRA launch control: FSM encoding and default sizing.
// Kept separate so a multi-kernel sequencer can reuse the same state view.
package cgra_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_ERR     = 2'd3
    } ctrl_state_e;

    localparam int unsigned DEF_CNT_WIDTH = 32;
    localparam logic [31:0] DEF_TIMEOUT   = 32'd1000000;
    localparam int unsigned DEF_RUN_WIDTH = 16;

    function automatic logic is_busy(input ctrl_state_e s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/cgra_sat_counter.sv
// Saturating up-counter with synchronous load-to-one and a terminal-value compare.
// A TERM of zero disables the terminal compare entirely.
module cgra_sat_counter #(
    parameter int unsigned       WIDTH = 32,
    parameter logic [WIDTH-1:0]  TERM  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             at_max,
    output logic             at_term
);

    assign at_max  = &cnt;
    assign at_term = (TERM != '0) && (cnt == TERM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= WIDTH'(1);
        else if (inc && !at_max)
            cnt <= cnt + WIDTH'(1);
    end

endmodule

// File: rtl/cgra_launch_ctrl.sv
// Host-side four-phase initiator for the CGRA Computation_Start/Computation_Done
// handshake, with latency measurement, run counting, timeout and protocol guard.
module cgra_launch_ctrl
    import cgra_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
    parameter logic [31:0] TIMEOUT   = DEF_TIMEOUT,
    parameter int unsigned RUN_WIDTH = DEF_RUN_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Launch,
    input  logic                 Abort,
    input  logic                 Clear,
    output logic                 Computation_Start,
    input  logic                 Computation_Done,
    output logic                 Busy,
    output logic                 Done_Pulse,
    output logic                 Timeout,
    output logic                 Proto_Err,
    output logic [CNT_WIDTH-1:0] Cycle_Count,
    output logic [RUN_WIDTH-1:0] Run_Count
);

    ctrl_state_e          state;
    logic                 done_q;
    logic                 cnt_load;
    logic                 cnt_max;
    logic                 cnt_term;
    logic [CNT_WIDTH-1:0] cnt;

    // Counter reads 1 during the first REQ cycle, so it tracks REQ cycles elapsed.
    assign cnt_load = (state == ST_IDLE) && Launch && !done_q;
    assign Busy     = is_busy(state);

    cgra_sat_counter #(
        .WIDTH (CNT_WIDTH),
        .TERM  (CNT_WIDTH'(TIMEOUT))
    ) u_lat_cnt (
        .clk     (Clk),
        .rst     (Rst),
        .load    (cnt_load),
        .inc     (state == ST_REQ),
        .cnt     (cnt),
        .at_max  (cnt_max),
        .at_term (cnt_term)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            done_q <= 1'b0;
        else
            done_q <= Computation_Done;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state             <= ST_IDLE;
            Computation_Start <= 1'b0;
            Done_Pulse        <= 1'b0;
            Timeout           <= 1'b0;
            Proto_Err         <= 1'b0;
            Cycle_Count       <= '0;
            Run_Count         <= '0;
        end else begin
            Done_Pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Launch) begin
                        if (done_q) begin
                            Proto_Err <= 1'b1;
                            state     <= ST_ERR;
                        end else begin
                            Computation_Start <= 1'b1;
                            state             <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // done_q lags the raw input by one edge, hence the minus one.
                    if (done_q) begin
                        Cycle_Count       <= cnt_max ? cnt : cnt - CNT_WIDTH'(1);
                        Computation_Start <= 1'b0;
                        state             <= ST_RELEASE;
                    end else if (Abort) begin
                        Computation_Start <= 1'b0;
                        state             <= ST_ERR;
                    end else if (cnt_term) begin
                        Timeout           <= 1'b1;
                        Computation_Start <= 1'b0;
                        state             <= ST_ERR;
                    end
                end
                ST_RELEASE: begin
                    if (!done_q) begin
                        Done_Pulse <= 1'b1;
                        Run_Count  <= Run_Count + RUN_WIDTH'(1);
                        state      <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    if (Clear && !done_q) begin
                        Timeout   <= 1'b0;
                        Proto_Err <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    Computation_Start <= 1'b0;
                    state             <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cgra_launch_ctrl.sv
// Randomized bench for cgra_launch_ctrl: each run is scored against a
// transaction-level model of when Start must drop and what the run reports.
module tb_cgra_launch_ctrl;

    localparam int CW  = 32;
    localparam int RW  = 4;
    localparam int T   = 8;
    localparam int INF = 1000;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Launch;
    logic          Abort;
    logic          Clear;
    logic          Computation_Start;
    logic          Computation_Done;
    logic          Busy;
    logic          Done_Pulse;
    logic          Timeout;
    logic          Proto_Err;
    logic [CW-1:0] Cycle_Count;
    logic [RW-1:0] Run_Count;

    int checks   = 0;
    int failures = 0;
    int exp_runs = 0;
    int exp_cc   = 0;

    always #5 Clk = ~Clk;

    cgra_launch_ctrl #(
        .CNT_WIDTH (CW),
        .TIMEOUT   (32'd8),
        .RUN_WIDTH (RW)
    ) dut (
        .Clk               (Clk),
        .Rst               (Rst),
        .Launch            (Launch),
        .Abort             (Abort),
        .Clear             (Clear),
        .Computation_Start (Computation_Start),
        .Computation_Done  (Computation_Done),
        .Busy              (Busy),
        .Done_Pulse        (Done_Pulse),
        .Timeout           (Timeout),
        .Proto_Err         (Proto_Err),
        .Cycle_Count       (Cycle_Count),
        .Run_Count         (Run_Count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, 32'(Computation_Start), 0);
        chk({tag, "_busy"},  32'(Busy), 0);
        chk({tag, "_pulse"}, 32'(Done_Pulse), 0);
        chk({tag, "_tmo"},   32'(Timeout), 0);
        chk({tag, "_perr"},  32'(Proto_Err), 0);
        chk({tag, "_cc"},    Cycle_Count, 0);
        chk({tag, "_rc"},    32'(Run_Count), 0);
    endtask

    // n: edge after Start rise at which Done is first sampled high (INF = never)
    // k: edge after Start rise at which Abort is sampled (INF = never)
    // d: extra edges Done is held after Start drops
    task automatic run_case(input int n, input int k, input int d);
        int  s, hi, w;
        bit  done_ok, abort_ok, hold;
        done_ok  = (n + 1 <= k) && (n + 1 <= T);
        abort_ok = !done_ok && (k <= T);
        s        = done_ok ? n + 1 : (abort_ok ? k : T);

        Launch = 1'b1; tick(); Launch = 1'b0;
        chk("start_rise", 32'(Computation_Start), 1);
        chk("busy_req",   32'(Busy), 1);
        chk("pulse_quiet", 32'(Done_Pulse), 0);

        hi = 0;
        for (int e = 1; e <= s; e++) begin
            Computation_Done = (e >= n);
            Abort            = (e == k);
            Launch           = (e < s) && ($urandom_range(0, 3) == 0);
            tick();
            if (e < s && Computation_Start) hi++;
        end
        Abort  = 1'b0;
        Launch = 1'b0;
        chk("start_len",  hi, s - 1);
        chk("start_drop", 32'(Computation_Start), 0);
        chk("busy_post",  32'(Busy), 1);

        if (done_ok) begin
            exp_cc = n;
            chk("cycle_count", Cycle_Count, exp_cc);
            chk("tmo_quiet",   32'(Timeout), 0);
            repeat (d) tick();
            Computation_Done = 1'b0;
            w = 0;
            while (w < 12) begin
                tick();
                w++;
                if (Done_Pulse) break;
            end
            exp_runs = (exp_runs + 1) % (1 << RW);
            chk("pulse_lat", w, 2);
            chk("run_count", 32'(Run_Count), exp_runs);
            chk("busy_idle", 32'(Busy), 0);
        end else begin
            chk("timeout_flag", 32'(Timeout), 32'(!abort_ok));
            chk("perr_quiet",   32'(Proto_Err), 0);
            chk("cc_hold",      Cycle_Count, exp_cc);
            hold = Computation_Done;
            Launch = 1'b1; tick(); Launch = 1'b0;
            chk("err_launch_ign", 32'(Busy), 1);
            chk("err_no_start",   32'(Computation_Start), 0);
            Clear = 1'b1; tick(); Clear = 1'b0;
            if (hold) begin
                chk("clear_ign", 32'(Busy), 1);
                Computation_Done = 1'b0;
                tick(); tick();
                Clear = 1'b1; tick(); Clear = 1'b0;
            end
            chk("clear_idle",  32'(Busy), 0);
            chk("tmo_cleared", 32'(Timeout), 0);
            chk("run_hold",    32'(Run_Count), exp_runs);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1; Launch = 1'b0; Abort = 1'b0; Clear = 1'b0; Computation_Done = 1'b0;
        #1;
        chk_all_zero("reset");
        tick(); tick();
        Rst = 1'b0;
        repeat (7) tick();

        run_case(5, INF, 3);    // nominal
        run_case(4, 5, 1);      // abort on the cycle done_q rises
        run_case(T - 1, INF, 0); // longest completing run
        run_case(INF, INF, 0);  // timeout
        run_case(T, INF, 2);    // Done arrives exactly at the timeout edge
        run_case(INF, T, 0);    // abort beats timeout
        run_case(3, 2, 0);      // early abort with Done raised later

        // Launch while the CGRA still holds Done
        Computation_Done = 1'b1; tick(); tick();
        Launch = 1'b1; tick(); Launch = 1'b0;
        chk("proto_flag",    32'(Proto_Err), 1);
        chk("proto_busy",    32'(Busy), 1);
        chk("proto_nostart", 32'(Computation_Start), 0);
        Clear = 1'b1; tick(); Clear = 1'b0;
        chk("proto_clear_ign", 32'(Proto_Err), 1);
        chk("proto_nostart2",  32'(Computation_Start), 0);
        Computation_Done = 1'b0; tick(); tick();
        Clear = 1'b1; tick(); Clear = 1'b0;
        chk("proto_cleared", 32'(Proto_Err), 0);
        chk("proto_idle",    32'(Busy), 0);

        // Reset in the middle of REQ
        Launch = 1'b1; tick(); Launch = 1'b0;
        tick(); tick();
        #2 Rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        exp_runs = 0;
        exp_cc   = 0;
        @(negedge Clk);
        Rst = 1'b0;
        tick();

        for (int i = 0; i < 60; i++) begin
            int n, k, d;
            n = $urandom_range(1, 10);
            k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : INF;
            d = $urandom_range(0, 3);
            run_case(n, k, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
